// File: rtl/bcd_addsub_serial_pkg.sv
// Shared types and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {IDLE, CHECK, CALC, FIX, DONE} state_t;

    function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
        return 4'd9 - d;
    endfunction

    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_addsub_serial_digit_adder.sv
// One-digit BCD adder: binary add with carry-in, then +6 correction when the result exceeds 9.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    logic [DIGIT_W:0]   w_bin;
    logic [DIGIT_W-1:0] w_adj;

    assign w_bin = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};
    assign co    = w_bin > 5'd9;
    // The +6 wraps the low nibble past 16, which is exactly the decimal digit we want.
    assign w_adj = w_bin[DIGIT_W-1:0] + 4'd6;
    assign s     = co ? w_adj : w_bin[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD add/subtract with sign-magnitude result and invalid-digit detection.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op,
    input  logic [DIGIT_W*NDIG-1:0] a,
    input  logic [DIGIT_W*NDIG-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGIT_W*NDIG-1:0] sum,
    output logic                    cout,
    output logic                    neg,
    output logic                    err
);

    localparam int W     = DIGIT_W * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t             r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_res;
    logic [W-1:0]       r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_op;
    logic               r_carry;
    logic               r_cout_flag;
    logic               r_neg_flag;
    logic               r_err_flag;
    logic               r_out_valid;
    logic               r_cout;
    logic               r_neg;
    logic               r_err;

    logic [NDIG-1:0]    w_digit_bad;
    logic               w_any_bad;
    logic               w_in_fix;
    logic [DIGIT_W-1:0] w_x;
    logic [DIGIT_W-1:0] w_y;
    logic [DIGIT_W-1:0] w_s;
    logic               w_co;
    logic [W+DIGIT_W-1:0] w_res_shift;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
            assign w_digit_bad[gi] = digit_invalid(r_a[gi*DIGIT_W +: DIGIT_W])
                                   | digit_invalid(r_b[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign w_any_bad = |w_digit_bad;

    // FIX negates the stored result: 0 + (9 - s_i) + c, reusing the same digit adder.
    assign w_in_fix = (r_state == FIX);
    assign w_x      = w_in_fix ? '0 : r_a[DIGIT_W-1:0];
    assign w_y      = w_in_fix ? nines_comp(r_res[DIGIT_W-1:0])
                    : (r_op ? nines_comp(r_b[DIGIT_W-1:0]) : r_b[DIGIT_W-1:0]);

    bcd_digit_adder u_digit_adder (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // New digit enters at the top so digit 0 lands at the bottom after NDIG steps.
    assign w_res_shift = {w_s, r_res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_op        <= 1'b0;
            r_carry     <= 1'b0;
            r_cout_flag <= 1'b0;
            r_neg_flag  <= 1'b0;
            r_err_flag  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_idx       <= '0;
                    r_carry     <= r_op;
                    r_res       <= '0;
                    r_cout_flag <= 1'b0;
                    r_neg_flag  <= 1'b0;
                    r_err_flag  <= w_any_bad;
                    r_state     <= w_any_bad ? DONE : CALC;
                end
                CALC: begin
                    r_a     <= r_a >> DIGIT_W;
                    r_b     <= r_b >> DIGIT_W;
                    r_res   <= w_res_shift[W+DIGIT_W-1:DIGIT_W];
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_idx <= '0;
                        if (!r_op) begin
                            r_cout_flag <= w_co;
                            r_state     <= DONE;
                        end else if (w_co) begin
                            r_state <= DONE;
                        end else begin
                            r_neg_flag <= 1'b1;
                            r_carry    <= 1'b1;
                            r_state    <= FIX;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                FIX: begin
                    r_res   <= w_res_shift[W+DIGIT_W-1:DIGIT_W];
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_sum       <= r_err_flag ? '0 : r_res;
                        r_cout      <= r_cout_flag & ~r_err_flag;
                        r_neg       <= r_neg_flag & ~r_err_flag;
                        r_err       <= r_err_flag;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign neg       = r_neg;
    assign err       = r_err;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial (NDIG=4): vector table, random model vectors, handshake and reset corners.
module tb_bcd_addsub_serial;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
        logic        neg;
        logic        err;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        neg;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t tbl[11];

    bcd_addsub_serial #(.NDIG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Decimal reference model, independent of the digit-serial datapath.
    function automatic vec_t model(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i);
        vec_t        v;
        int          av;
        int          bv;
        int          r;
        bit          bad;
        logic [3:0]  da;
        logic [3:0]  db;
        v.op = op_i; v.a = a_i; v.b = b_i;
        v.cout = 1'b0; v.neg = 1'b0; v.err = 1'b0; v.sum = '0;
        av = 0; bv = 0; r = 0; bad = 0;
        for (int i = 3; i >= 0; i--) begin
            da = a_i[i*4 +: 4];
            db = b_i[i*4 +: 4];
            if (da > 4'd9 || db > 4'd9) bad = 1;
            av = av * 10 + int'(da);
            bv = bv * 10 + int'(db);
        end
        if (bad) begin
            v.err = 1'b1;
            v.lat = 2;
            return v;
        end
        v.lat = 6;
        if (!op_i) begin
            r = av + bv;
            v.cout = (r >= 10000);
            r = r % 10000;
        end else if (av >= bv) begin
            r = av - bv;
        end else begin
            r = bv - av;
            v.neg = 1'b1;
            v.lat = 10;
        end
        for (int i = 0; i < 4; i++) begin
            v.sum[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return v;
    endfunction

    task automatic send(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_arrives", 32'(out_valid), 32'd1);
    endtask

    task automatic pop_check(input int lat);
        vec_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        $display("txn op=%0d a=%04h b=%04h -> sum=%04h cout=%0d neg=%0d err=%0d lat=%0d (want %04h %0d %0d %0d %0d)",
                 e.op, e.a, e.b, sum, cout, neg, err, lat, e.sum, e.cout, e.neg, e.err, e.lat);
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("neg", 32'(neg), 32'(e.neg));
        check("err", 32'(err), 32'(e.err));
        check("latency", 32'(lat), 32'(e.lat));
    endtask

    task automatic run_txn(input vec_t e);
        int lat;
        exp_q.push_back(e);
        send(e.op, e.a, e.b);
        wait_valid(lat);
        pop_check(lat);
        @(negedge clk);
        check("out_valid_single_cycle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t        v;
        int          lat;
        logic [15:0] held;
        logic [15:0] ra;
        logic [15:0] rb;
        bit          seen;

        tbl[0]  = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 6};
        tbl[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 6};
        tbl[2]  = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 6};
        tbl[3]  = '{1'b1, 16'h0012, 16'h0345, 16'h0333, 1'b0, 1'b1, 1'b0, 10};
        tbl[4]  = '{1'b1, 16'h0777, 16'h0777, 16'h0000, 1'b0, 1'b0, 1'b0, 6};
        tbl[5]  = '{1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 2};
        tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 6};
        tbl[7]  = '{1'b1, 16'h0000, 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0, 10};
        tbl[8]  = '{1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 1'b0, 6};
        tbl[9]  = '{1'b1, 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 1'b0, 6};
        tbl[10] = '{1'b1, 16'h0100, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_flags", 32'({cout, neg, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 4; d++) begin
                ra[d*4 +: 4] = 4'($urandom_range(9));
                rb[d*4 +: 4] = 4'($urandom_range(9));
            end
            run_txn(model(1'($urandom_range(1)), ra, rb));
        end

        // Back-pressure in DONE: outputs hold, in_ready low, extra in_valid ignored.
        out_ready = 1'b0;
        v = '{1'b0, 16'h0123, 16'h0456, 16'h0579, 1'b0, 1'b0, 1'b0, 6};
        exp_q.push_back(v);
        send(v.op, v.a, v.b);
        wait_valid(lat);
        pop_check(lat);
        held = sum;
        for (int k = 0; k < 3; k++) begin
            op = 1'b0; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release_transfer", 32'(out_valid), 32'd0);
        check("hold_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("ignored_input_no_result", 32'(seen), 32'd0);

        // Reset during the second CALC cycle aborts without a result.
        send(1'b0, 16'h1234, 16'h5678);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_flags", 32'({cout, neg, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("midreset_no_partial", 32'(seen), 32'd0);
        run_txn('{1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 6});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
